// File: rtl/sauria_eoc_pkg.sv
// Shared definitions for the SAURIA end-of-computation mailbox:
// register byte offsets, run-state encoding and the default watchdog exit code.
package sauria_eoc_pkg;

   localparam logic [4:0] OFF_EOC      = 5'h00;
   localparam logic [4:0] OFF_STATUS   = 5'h04;
   localparam logic [4:0] OFF_TIMEOUT  = 5'h08;
   localparam logic [4:0] OFF_CYCLE_LO = 5'h0C;
   localparam logic [4:0] OFF_CYCLE_HI = 5'h10;
   localparam logic [4:0] OFF_DONE_CNT = 5'h14;

   localparam logic [31:0] DEFAULT_TIMEOUT_CODE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DONE    = 2'd1,
      ST_TIMEOUT = 2'd2
   } eoc_state_e;

endpackage

// File: rtl/sauria_eoc_mailbox.sv
// End-of-computation mailbox: software exit code, run-cycle counter,
// SAURIA done-pulse counter and a watchdog that forces a timeout exit code.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_RUN     | computation running, cycle counter advancing, watchdog armed
//   ST_DONE    | software wrote its exit code; counter frozen; terminal
//   ST_TIMEOUT | watchdog expired; exit code forced; counter frozen; terminal
module sauria_eoc_mailbox
   import sauria_eoc_pkg::*;
#(
   parameter int unsigned AddrWidth   = 32,
   parameter logic [31:0] TimeoutRst  = 32'd0,
   parameter logic [31:0] TimeoutCode = DEFAULT_TIMEOUT_CODE
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,

   input  logic                 reg_valid_i,
   input  logic                 reg_write_i,
   input  logic [AddrWidth-1:0] reg_addr_i,
   input  logic [31:0]          reg_wdata_i,
   input  logic [3:0]           reg_wstrb_i,
   output logic                 reg_ready_o,
   output logic [31:0]          reg_rdata_o,
   output logic                 reg_error_o,

   input  logic                 sauria_done_i,

   output logic                 eoc_o,
   output logic [31:0]          exit_code_o,
   output logic                 timeout_o
);

   eoc_state_e  state_q, state_d;
   logic [63:0] cycle_q, cycle_d;
   logic [31:0] cycle_hi_shadow_q, cycle_hi_shadow_d;
   logic [31:0] timeout_q, timeout_d;
   logic [31:0] done_cnt_q, done_cnt_d;
   logic [31:0] exit_code_q, exit_code_d;
   logic        eoc_q, eoc_d;
   logic        timeout_fired_q, timeout_fired_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [4:0]  reg_offset;
   logic        accept;
   logic        eoc_write;
   logic        wdog_expire;
   logic        addr_unused;

   // Only addr[4:2] selects a register; the remaining address bits are ignored.
   assign reg_offset  = {reg_addr_i[4:2], 2'b00};
   assign addr_unused = ^{reg_addr_i[AddrWidth-1:5], reg_addr_i[1:0]};

   // Counter value is compared against TIMEOUT-1 so expiry lands on the TIMEOUT-th cycle.
   assign wdog_expire = (state_q == ST_RUN) && (timeout_q != 32'd0) &&
                        (cycle_q == {32'd0, timeout_q - 32'd1});

   assign done_cnt_d = (sauria_done_i && (done_cnt_q != 32'hFFFF_FFFF)) ?
                       done_cnt_q + 32'd1 : done_cnt_q;

   always_comb begin
      ready_d           = 1'b0;
      rdata_d           = 32'd0;
      error_d           = 1'b0;
      timeout_d         = timeout_q;
      cycle_hi_shadow_d = cycle_hi_shadow_q;
      eoc_write         = 1'b0;
      accept            = reg_valid_i && !ready_q;

      if (accept) begin
         ready_d = 1'b1;
         case (reg_offset)
            OFF_EOC: begin
               if (reg_write_i) begin
                  if (reg_wstrb_i != 4'hF) begin
                     error_d = 1'b1;
                  end else begin
                     eoc_write = reg_wdata_i[0] && (state_q == ST_RUN);
                  end
               end else begin
                  rdata_d = {exit_code_q[30:0], eoc_q};
               end
            end
            OFF_STATUS: begin
               if (reg_write_i) begin
                  error_d = 1'b1;
               end else begin
                  rdata_d = {29'd0, timeout_fired_q, state_q == ST_DONE, state_q == ST_RUN};
               end
            end
            OFF_TIMEOUT: begin
               if (reg_write_i) begin
                  for (int b = 0; b < 4; b++) begin
                     if (reg_wstrb_i[b]) begin
                        timeout_d[8*b +: 8] = reg_wdata_i[8*b +: 8];
                     end
                  end
               end else begin
                  rdata_d = timeout_q;
               end
            end
            OFF_CYCLE_LO: begin
               if (reg_write_i) begin
                  error_d = 1'b1;
               end else begin
                  rdata_d           = cycle_q[31:0];
                  cycle_hi_shadow_d = cycle_q[63:32];
               end
            end
            OFF_CYCLE_HI: begin
               if (reg_write_i) begin
                  error_d = 1'b1;
               end else begin
                  rdata_d = cycle_hi_shadow_q;
               end
            end
            OFF_DONE_CNT: begin
               if (reg_write_i) begin
                  error_d = 1'b1;
               end else begin
                  rdata_d = done_cnt_q;
               end
            end
            default: begin
               error_d = 1'b1;
            end
         endcase
      end
   end

   // A software EOC write takes priority over a watchdog expiry in the same cycle.
   always_comb begin
      state_d         = state_q;
      exit_code_d     = exit_code_q;
      timeout_fired_d = timeout_fired_q;
      cycle_d         = cycle_q;

      case (state_q)
         ST_RUN: begin
            if (eoc_write) begin
               state_d     = ST_DONE;
               exit_code_d = {1'b0, reg_wdata_i[31:1]};
            end else if (wdog_expire) begin
               state_d         = ST_TIMEOUT;
               exit_code_d     = TimeoutCode;
               timeout_fired_d = 1'b1;
            end else begin
               cycle_d = cycle_q + 64'd1;
            end
         end
         default: begin
         end
      endcase

      eoc_d = (state_d != ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q           <= ST_RUN;
         cycle_q           <= 64'd0;
         cycle_hi_shadow_q <= 32'd0;
         timeout_q         <= TimeoutRst;
         done_cnt_q        <= 32'd0;
         exit_code_q       <= 32'd0;
         eoc_q             <= 1'b0;
         timeout_fired_q   <= 1'b0;
         ready_q           <= 1'b0;
         rdata_q           <= 32'd0;
         error_q           <= 1'b0;
      end else begin
         state_q           <= state_d;
         cycle_q           <= cycle_d;
         cycle_hi_shadow_q <= cycle_hi_shadow_d;
         timeout_q         <= timeout_d;
         done_cnt_q        <= done_cnt_d;
         exit_code_q       <= exit_code_d;
         eoc_q             <= eoc_d;
         timeout_fired_q   <= timeout_fired_d;
         ready_q           <= ready_d;
         rdata_q           <= rdata_d;
         error_q           <= error_d;
      end
   end

   assign reg_ready_o = ready_q;
   assign reg_rdata_o = rdata_q;
   assign reg_error_o = error_q;
   assign eoc_o       = eoc_q;
   assign exit_code_o = exit_code_q;
   assign timeout_o   = timeout_fired_q;

endmodule

// File: tb/tb_sauria_eoc_mailbox.sv
// Scoreboard bench for the EOC mailbox: a behavioural model predicts every bus
// response and the sticky outputs; a monitor compares whenever the DUT responds.
module tb_sauria_eoc_mailbox;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reg_valid = 1'b0;
   logic        reg_write = 1'b0;
   logic [31:0] reg_addr = 32'd0;
   logic [31:0] reg_wdata = 32'd0;
   logic [3:0]  reg_wstrb = 4'd0;
   logic        sauria_done = 1'b0;
   logic        reg_ready_o;
   logic [31:0] reg_rdata_o;
   logic        reg_error_o;
   logic        eoc_o;
   logic [31:0] exit_code_o;
   logic        timeout_o;

   sauria_eoc_mailbox dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .reg_valid_i   (reg_valid),
      .reg_write_i   (reg_write),
      .reg_addr_i    (reg_addr),
      .reg_wdata_i   (reg_wdata),
      .reg_wstrb_i   (reg_wstrb),
      .reg_ready_o   (reg_ready_o),
      .reg_rdata_o   (reg_rdata_o),
      .reg_error_o   (reg_error_o),
      .sauria_done_i (sauria_done),
      .eoc_o         (eoc_o),
      .exit_code_o   (exit_code_o),
      .timeout_o     (timeout_o)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t       exp_q[$];
   int          checks = 0;
   int          failures = 0;
   bit          rand_done = 1'b0;

   // Reference model state: whether the run has ended, and why.
   bit          m_ended, m_to_fired, m_pending;
   logic [31:0] m_code, m_to, m_done_cnt, m_shadow;
   logic [63:0] m_cnt;
   int unsigned edges;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ended    = 1'b0;
      m_to_fired = 1'b0;
      m_pending  = 1'b0;
      m_code     = 32'd0;
      m_to       = 32'd0;
      m_done_cnt = 32'd0;
      m_shadow   = 32'd0;
      m_cnt      = 64'd0;
      edges      = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit          accept, fire, sw_end;
      logic [2:0]  idx;
      resp_t       r;
      edges++;
      accept = reg_valid && !m_pending;
      fire   = !m_ended && (m_to != 32'd0) && (m_cnt == {32'd0, m_to} - 64'd1);
      sw_end = 1'b0;
      if (accept) begin
         r.rdata = 32'd0;
         r.err   = 1'b0;
         idx     = reg_addr[4:2];
         if (reg_write) begin
            case (idx)
               3'd0: begin
                  if (reg_wstrb != 4'hF) r.err = 1'b1;
                  else if (reg_wdata[0] && !m_ended) sw_end = 1'b1;
               end
               3'd2: begin
                  for (int b = 0; b < 4; b++)
                     if (reg_wstrb[b]) m_to[8*b +: 8] = reg_wdata[8*b +: 8];
               end
               default: r.err = 1'b1;
            endcase
         end else begin
            case (idx)
               3'd0: r.rdata = {m_code[30:0], m_ended};
               3'd1: r.rdata = {29'd0, m_to_fired, m_ended && !m_to_fired, !m_ended};
               3'd2: r.rdata = m_to;
               3'd3: begin
                  r.rdata  = m_cnt[31:0];
                  m_shadow = m_cnt[63:32];
               end
               3'd4: r.rdata = m_shadow;
               3'd5: r.rdata = m_done_cnt;
               default: r.err = 1'b1;
            endcase
         end
         exp_q.push_back(r);
      end
      if (sw_end) begin
         m_ended = 1'b1;
         m_code  = {1'b0, reg_wdata[31:1]};
      end else if (fire) begin
         m_ended    = 1'b1;
         m_to_fired = 1'b1;
         m_code     = 32'hFFFF_FFFF;
      end else if (!m_ended) begin
         m_cnt = m_cnt + 64'd1;
      end
      if (sauria_done && (m_done_cnt != 32'hFFFF_FFFF)) m_done_cnt = m_done_cnt + 32'd1;
      m_pending = accept;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   resp_t mon_r;
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("ready", 32'(reg_ready_o), 32'(m_pending));
         check("eoc_o", 32'(eoc_o), 32'(m_ended));
         check("timeout_o", 32'(timeout_o), 32'(m_to_fired));
         check("exit_code_o", exit_code_o, m_code);
         if (reg_ready_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: actual=ready required=no_response (t=%0t)", $time);
            end else begin
               mon_r = exp_q.pop_front();
               check("rdata", reg_rdata_o, mon_r.rdata);
               check("error", 32'(reg_error_o), 32'(mon_r.err));
            end
         end
      end
   end

   task automatic drive_done();
      sauria_done = rand_done ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         drive_done();
      end
   endtask

   // Called at a falling edge; returns at the falling edge where the response is seen.
   task automatic bus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output logic er);
      bit got = 1'b0;
      reg_valid = 1'b1;
      reg_write = wr;
      reg_addr  = addr;
      reg_wdata = wd;
      reg_wstrb = ws;
      rd = 32'd0;
      er = 1'b0;
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         drive_done();
         if (reg_ready_o) begin
            got = 1'b1;
            rd  = reg_rdata_o;
            er  = reg_error_o;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL bus_timeout: actual=no_ready required=ready addr=0x%0h", addr);
      end
      reg_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n       = 1'b0;
      reg_valid   = 1'b0;
      sauria_done = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(reg_ready_o), 0);
      check("rst_rdata", reg_rdata_o, 0);
      check("rst_error", 32'(reg_error_o), 0);
      check("rst_eoc", 32'(eoc_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      check("rst_exit", exit_code_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [31:0] rd;
   logic        er;
   bit          got;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      // Basic software EOC with code 0, plus reset register values.
      do_reset();
      bus(0, 32'h0C, 0, 0, rd, er);       check("rst_cycle_lo", rd, 0);
      bus(0, 32'h08, 0, 0, rd, er);       check("rst_timeout_reg", rd, 0);
      bus(0, 32'h14, 0, 0, rd, er);       check("rst_done_cnt", rd, 0);
      bus(0, 32'h04, 0, 0, rd, er);       check("status_run", rd, 32'h1);
      bus(1, 32'h00, 32'h1, 4'hF, rd, er);
      check("eoc1_err", 32'(er), 0);
      check("eoc1_eoc", 32'(eoc_o), 1);
      check("eoc1_code", exit_code_o, 0);
      bus(0, 32'h04, 0, 0, rd, er);       check("status_done", rd, 32'h2);
      bus(0, 32'h00, 0, 0, rd, er);       check("eoc_read1", rd, 32'h1);

      // First code is kept.
      do_reset();
      bus(1, 32'h00, 32'h55, 4'hF, rd, er);
      check("code_2a", exit_code_o, 32'h2A);
      bus(1, 32'h00, 32'h3, 4'hF, rd, er);
      check("code_kept", exit_code_o, 32'h2A);
      check("code_kept_err", 32'(er), 0);
      bus(0, 32'h00, 0, 0, rd, er);       check("eoc_read_2a", rd, 32'h55);

      // Watchdog at 100 cycles.
      do_reset();
      bus(1, 32'h08, 32'd100, 4'hF, rd, er);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (eoc_o) got = 1'b1;
      end
      check("wdog_cycle", edges, 100);
      check("wdog_timeout", 32'(timeout_o), 1);
      check("wdog_code", exit_code_o, 32'hFFFF_FFFF);
      bus(0, 32'h0C, 0, 0, rd, er);       check("wdog_cycle_lo", rd, 99);
      bus(0, 32'h10, 0, 0, rd, er);       check("wdog_cycle_hi", rd, 0);
      bus(0, 32'h04, 0, 0, rd, er);       check("status_timeout", rd, 32'h4);

      // EOC write accepted on the expiry edge wins.
      do_reset();
      bus(1, 32'h08, 32'd60, 4'hF, rd, er);
      while (edges < 59) @(negedge clk);
      bus(1, 32'h00, 32'h77, 4'hF, rd, er);
      check("race_timeout", 32'(timeout_o), 0);
      check("race_code", exit_code_o, 32'h3B);
      idle(5);
      check("race_timeout_late", 32'(timeout_o), 0);

      // Error responses, strobed TIMEOUT writes, TIMEOUT below the counter.
      do_reset();
      bus(0, 32'h1C, 0, 0, rd, er);       check("err_rd1c", 32'(er), 1);  check("err_rd1c_data", rd, 0);
      bus(0, 32'h18, 0, 0, rd, er);       check("err_rd18", 32'(er), 1);
      bus(1, 32'h0C, 32'h5, 4'hF, rd, er); check("err_wr0c", 32'(er), 1);
      bus(1, 32'h04, 32'h5, 4'hF, rd, er); check("err_wr04", 32'(er), 1);
      bus(1, 32'h00, 32'h1, 4'h3, rd, er); check("err_wstrb", 32'(er), 1);
      check("err_wstrb_eoc", 32'(eoc_o), 0);
      bus(0, 32'h04, 0, 0, rd, er);       check("err_status", rd, 32'h1);
      bus(1, 32'h08, 32'hAABB_CCDD, 4'hF, rd, er);
      bus(1, 32'h08, 32'h1122_3344, 4'b0101, rd, er);
      bus(0, 32'h08, 0, 0, rd, er);       check("strobe_timeout", rd, 32'hAA22_CC44);
      bus(1, 32'h08, 32'd3, 4'hF, rd, er);
      idle(30);
      check("late_timeout_no_fire", 32'(eoc_o), 0);

      // Done pulses, then reset in the middle of a read.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sauria_done = 1'b1;
         @(negedge clk);
         sauria_done = 1'b0;
         idle(i % 3 + 1);
      end
      bus(0, 32'h14, 0, 0, rd, er);       check("done_cnt5", rd, 5);
      bus(1, 32'h00, 32'h9, 4'hF, rd, er);
      reg_valid = 1'b1;
      reg_write = 1'b0;
      reg_addr  = 32'h14;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(reg_ready_o), 0);
      check("midrst_eoc", 32'(eoc_o), 0);
      check("midrst_exit", exit_code_o, 0);
      check("midrst_timeout", 32'(timeout_o), 0);
      @(negedge clk);
      reg_valid = 1'b0;

      // Randomized traffic against the model.
      rand_done = 1'b1;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         if ($urandom_range(0, 2) != 0)
            bus(1, 32'h08, $urandom_range(30, 250), 4'hF, rd, er);
         for (int t = 0; t < 40; t++) begin
            logic [2:0]  idx;
            logic [31:0] a, d;
            logic [3:0]  s;
            bit          w;
            idx = 3'($urandom_range(0, 7));
            w   = $urandom_range(0, 1) == 1;
            a   = ($urandom & ~32'h1C) | {27'd0, idx, 2'b00};
            d   = $urandom;
            if (idx == 3'd0) d[0] = ($urandom_range(0, 7) == 0);
            if (idx == 3'd2 && w) d = $urandom_range(1, 400);
            s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            bus(w, a, d, s, rd, er);
            idle($urandom_range(0, 3));
         end
      end
      rand_done = 1'b0;
      idle(3);
      check("queue_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
